// File: rtl/hpdcache_mem_read_otx_limiter.sv
// Outstanding read transaction limiter in front of the mem-to-AXI read path.
// Caps in-flight reads, supports drain, and flags timeouts and bad responses.
package hpdcache_mem_otx_pkg;
  localparam logic [1:0] HPDCACHE_MEM_RESP_OK  = 2'b00;
  localparam logic [1:0] HPDCACHE_MEM_RESP_NOK = 2'b10;

  typedef struct packed {
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_id;
  } mem_req_t;

  typedef struct packed {
    logic [1:0]  mem_resp_r_error;
    logic [3:0]  mem_resp_r_id;
    logic [31:0] mem_resp_r_data;
    logic        mem_resp_r_last;
  } mem_resp_r_t;
endpackage

module hpdcache_mem_read_otx_limiter #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter type hpdcache_mem_req_t =
    hpdcache_mem_otx_pkg::mem_req_t,
  parameter type hpdcache_mem_resp_r_t =
    hpdcache_mem_otx_pkg::mem_resp_r_t,
  localparam int unsigned CntW =
    $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  hpdcache_mem_req_t    req_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output hpdcache_mem_req_t    req_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  hpdcache_mem_resp_r_t resp_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output hpdcache_mem_resp_r_t resp_o,
  input  logic                 drain_i,
  output logic                 drained_o,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 timeout_o,
  output logic                 error_o,
  input  logic                 error_clr_i
);

  localparam int unsigned TmrW =
    (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam int unsigned TmrLastI =
    (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TmrLastI);
  localparam logic [TmrW-1:0] TmrSat = '1;
  localparam bit TmoEn = (TimeoutCycles != 0);

  logic [CntW-1:0] cnt, cnt_next;
  logic [TmrW-1:0] timer, timer_next;
  logic            timeout_q, error_q;
  logic            stall, issue, beat, retire;
  logic            underflow, nok, err_set, tmo_set;

  // Stall uses only registered count and drain: no resp-to-req path.
  assign stall = (cnt == CntMax) || drain_i;

  assign req_valid_o  = req_valid_i && !stall;
  assign req_ready_o  = req_ready_i && !stall;
  assign req_o        = req_i;
  assign resp_valid_o = resp_valid_i;
  assign resp_ready_o = resp_ready_i;
  assign resp_o       = resp_i;

  assign issue  = req_valid_o && req_ready_i;
  assign beat   = resp_valid_i && resp_ready_i;
  assign retire = beat && resp_i.mem_resp_r_last;

  assign underflow = retire && (cnt == '0);
  assign nok = beat && (resp_i.mem_resp_r_error ==
    hpdcache_mem_otx_pkg::HPDCACHE_MEM_RESP_NOK);
  assign err_set = underflow || nok;
  assign tmo_set = TmoEn && (cnt != '0) && !beat &&
    (timer == TmrLast);

  assign drained_o     = drain_i && (cnt == '0);
  assign outstanding_o = cnt;
  assign timeout_o     = timeout_q;
  assign error_o       = error_q;

  // In-flight count: +issue -retire, floored at zero.
  always_comb begin
    cnt_next = cnt;
    unique case (1'b1)
      issue && !retire:
        cnt_next = cnt + 1'b1;
      !issue && retire && (cnt != '0):
        cnt_next = cnt - 1'b1;
      default:
        cnt_next = cnt;
    endcase
  end

  // Response-silence timer, restarted by idle or any beat.
  always_comb begin
    timer_next = timer;
    if ((cnt == '0) || beat) begin
      timer_next = '0;
    end else if (timer != TmrSat) begin
      timer_next = timer + 1'b1;
    end
  end

  // Count and timer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      timer <= '0;
    end else begin
      cnt   <= cnt_next;
      timer <= timer_next;
    end
  end

  // Sticky flags; a set beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (tmo_set) begin
        timeout_q <= 1'b1;
      end else if (error_clr_i) begin
        timeout_q <= 1'b0;
      end
      if (err_set) begin
        error_q <= 1'b1;
      end else if (error_clr_i) begin
        error_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_read_otx_limiter.sv
// Bench for hpdcache_mem_read_otx_limiter.
// Vector table for comb paths, scripted sequences plus payload scoreboard.
module tb_hpdcache_mem_read_otx_limiter;
  import hpdcache_mem_otx_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  mem_req_t    req_i, req_o;
  logic        req_valid_o, req_ready_i;
  logic        resp_valid_i, resp_ready_o;
  mem_resp_r_t resp_i, resp_o;
  logic        resp_valid_o, resp_ready_i;
  logic        drain_i, drained_o;
  logic [3:0]  outstanding_o;
  logic        timeout_o, error_o, error_clr_i;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] req_q[$];
  logic [63:0] resp_q[$];

  typedef struct {
    logic rv, rr, dr, pv, pr;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[8];

  hpdcache_mem_read_otx_limiter #(
    .MaxOutstanding(8),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_i(req_i),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .req_o(req_o),
    .resp_valid_i(resp_valid_i),
    .resp_ready_o(resp_ready_o),
    .resp_i(resp_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_o(resp_o),
    .drain_i(drain_i),
    .drained_o(drained_o),
    .outstanding_o(outstanding_o),
    .timeout_o(timeout_o),
    .error_o(error_o),
    .error_clr_i(error_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    req_valid_i  = 1'b0;
    req_ready_i  = 1'b0;
    req_i        = '0;
    resp_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    resp_i       = '0;
    drain_i      = 1'b0;
    error_clr_i  = 1'b0;
  endtask

  task automatic drv_req(input logic [31:0] a,
                         input bit accept);
    mem_req_t r;
    r.mem_req_addr = a;
    r.mem_req_id   = a[3:0];
    req_valid_i = 1'b1;
    req_ready_i = 1'b1;
    req_i       = r;
    if (accept) req_q.push_back(64'(r));
  endtask

  task automatic no_req();
    req_valid_i = 1'b0;
    req_ready_i = 1'b0;
    req_i       = '0;
  endtask

  task automatic drv_beat(input logic [31:0] d,
                          input logic last,
                          input logic [1:0] err);
    mem_resp_r_t b;
    b.mem_resp_r_error = err;
    b.mem_resp_r_id    = d[3:0];
    b.mem_resp_r_data  = d;
    b.mem_resp_r_last  = last;
    resp_valid_i = 1'b1;
    resp_ready_i = 1'b1;
    resp_i       = b;
    resp_q.push_back(64'(b));
  endtask

  task automatic no_beat();
    resp_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    resp_i       = '0;
  endtask

  // Scoreboard: compare payloads of every handshake seen downstream.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_valid_o && req_ready_i) begin
        if (req_q.size() == 0) chk("req_unexpected", 1, 0);
        else chk("req_payload", 64'(req_o), req_q.pop_front());
      end
      if (resp_valid_o && resp_ready_i) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_payload", 64'(resp_o), resp_q.pop_front());
      end
    end
  end

  initial begin
    //           rv    rr    dr    pv    pr    {rvo,rro,pvo,pro,drn}
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00101};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00110};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00011};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11010};

    idle();
    rst_ni = 1'b0;
    repeat (2) step();
    chk("rst_cnt", outstanding_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_drained", drained_o, 0);
    drain_i = 1'b1;
    #1 chk("rst_drained_drain", drained_o, 1);
    drain_i = 1'b0;
    rst_ni = 1'b1;
    step();

    // Combinational paths at cnt==0, cleared before the next edge.
    for (int i = 0; i < 8; i++) begin
      step();
      req_valid_i  = tbl[i].rv;
      req_ready_i  = tbl[i].rr;
      drain_i      = tbl[i].dr;
      resp_valid_i = tbl[i].pv;
      resp_ready_i = tbl[i].pr;
      #1;
      chk($sformatf("tbl%0d", i),
          {req_valid_o, req_ready_o, resp_valid_o,
           resp_ready_o, drained_o}, tbl[i].exp);
      idle();
    end
    step();
    chk("tbl_cnt", outstanding_o, 0);

    // Eight back-to-back reads fill the limiter.
    for (int i = 0; i < 8; i++) begin
      drv_req(32'h100 + i, 1'b1);
      #1 chk("fill_ready", req_ready_o, 1);
      step();
      chk($sformatf("fill_cnt%0d", i + 1), outstanding_o, i + 1);
    end
    drv_req(32'h200, 1'b0);
    #1;
    chk("full_ready", req_ready_o, 0);
    chk("full_valid", req_valid_o, 0);
    step();
    chk("full_hold", outstanding_o, 8);

    // Retire while full: no unstall in the same cycle.
    drv_beat(32'hA0, 1'b1, HPDCACHE_MEM_RESP_OK);
    #1 chk("full_retire_rdy", req_ready_o, 0);
    step();
    no_beat();
    chk("full_cnt7", outstanding_o, 7);
    req_q.push_back(64'(req_i));
    #1 chk("unstall_valid", req_valid_o, 1);
    step();
    no_req();
    chk("refill_cnt8", outstanding_o, 8);

    // Four-beat burst retires only on the last beat.
    for (int i = 0; i < 4; i++) begin
      drv_beat(32'hB0 + i, i == 3, HPDCACHE_MEM_RESP_OK);
      step();
      chk($sformatf("burst%0d", i), outstanding_o, i == 3 ? 7 : 8);
    end
    for (int i = 0; i < 4; i++) begin
      drv_beat(32'hC0 + i, 1'b1, HPDCACHE_MEM_RESP_OK);
      step();
    end
    no_beat();
    chk("down_cnt3", outstanding_o, 3);

    // Simultaneous issue and retire.
    drv_req(32'h300, 1'b1);
    drv_beat(32'hD0, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_req();
    no_beat();
    chk("sim_cnt3", outstanding_o, 3);

    // NOK beat sets error, beat forwarded, count untouched.
    drv_beat(32'hE0, 1'b0, HPDCACHE_MEM_RESP_NOK);
    step();
    no_beat();
    chk("nok_err", error_o, 1);
    chk("nok_cnt", outstanding_o, 3);
    error_clr_i = 1'b1;
    step();
    error_clr_i = 1'b0;
    chk("clr_err", error_o, 0);
    drv_beat(32'hE1, 1'b0, HPDCACHE_MEM_RESP_NOK);
    error_clr_i = 1'b1;
    step();
    no_beat();
    error_clr_i = 1'b0;
    chk("set_wins", error_o, 1);
    error_clr_i = 1'b1;
    step();
    error_clr_i = 1'b0;
    chk("clr_err2", error_o, 0);
    drv_beat(32'hE2, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("pre_drain_cnt", outstanding_o, 2);

    // Drain blocks requests; responses still flow.
    drain_i = 1'b1;
    drv_req(32'h400, 1'b0);
    #1;
    chk("drain_valid", req_valid_o, 0);
    chk("drain_ready", req_ready_o, 0);
    chk("drain_not_done", drained_o, 0);
    step();
    chk("drain_cnt2", outstanding_o, 2);
    drv_beat(32'hF0, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    chk("drain_cnt1", outstanding_o, 1);
    chk("drain_d1", drained_o, 0);
    drv_beat(32'hF1, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("drain_cnt0", outstanding_o, 0);
    chk("drained", drained_o, 1);
    no_req();
    drain_i = 1'b0;
    #1 chk("undrain", drained_o, 0);

    // Retire underflow.
    drv_beat(32'h55, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("uflow_err", error_o, 1);
    chk("uflow_cnt", outstanding_o, 0);
    error_clr_i = 1'b1;
    step();
    error_clr_i = 1'b0;
    chk("uflow_clr", error_o, 0);

    // Timeout, restarted by a non-last beat in cycle 10.
    drv_req(32'h500, 1'b1);
    step();
    no_req();
    chk("tmo_cnt1", outstanding_o, 1);
    repeat (9) step();
    drv_beat(32'h66, 1'b0, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("tmo_after_beat", timeout_o, 0);
    repeat (6) step();
    chk("tmo_restarted", timeout_o, 0);
    repeat (9) step();
    chk("tmo_edge_minus1", timeout_o, 0);
    step();
    chk("tmo_set", timeout_o, 1);
    chk("tmo_no_err", error_o, 0);
    error_clr_i = 1'b1;
    step();
    error_clr_i = 1'b0;
    chk("tmo_clr", timeout_o, 0);
    drv_beat(32'h67, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("tmo_done_cnt", outstanding_o, 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) begin
      drv_req(32'h600 + i, 1'b1);
      step();
    end
    no_req();
    drv_beat(32'h70, 1'b0, HPDCACHE_MEM_RESP_NOK);
    step();
    no_beat();
    chk("mid_cnt3", outstanding_o, 3);
    chk("mid_err", error_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_cnt", outstanding_o, 0);
    chk("arst_err", error_o, 0);
    chk("arst_tmo", timeout_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    drv_beat(32'h71, 1'b1, HPDCACHE_MEM_RESP_OK);
    step();
    no_beat();
    chk("late_beat_err", error_o, 1);
    chk("late_beat_cnt", outstanding_o, 0);

    step();
    chk("req_q_empty", req_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
